// File: rtl/rd_buffer_axi_if.sv
// rtl/rd_buffer_axi_if.sv - AXI4 read address and read data channels of the refill engine
interface rd_buffer_axi_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/rd_buffer_axi.sv
// rtl/rd_buffer_axi.sv - cache-refill AXI4 read engine assembling a 16 x 32-bit line
// Optional rresp error flag enabled by CLAP_AXI_RRESP_CHECK_EN.
module rd_buffer_axi (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_req,
   input  logic [31:0]            rd_addr,
   input  logic                   uncache,
   input  logic                   rd_reset,
   rd_buffer_axi_if.master        axi,
   output logic [511:0]           r_line,
   output logic                   rd_AXI_finish,
   output logic                   rd_err
);
   typedef enum logic [1:0] {IDLE, ADDR, RECV, FINISH} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  count;
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic        req_take;
   logic        beat_take;

   assign req_take  = (state == IDLE) && rd_req;
   assign beat_take = (state == RECV) && axi.rvalid;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      axi.arvalid   = 1'b0;
      axi.rready    = 1'b0;
      rd_AXI_finish = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req) state_nxt = ADDR;
         end
         ADDR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) state_nxt = RECV;
         end
         RECV: begin
            axi.rready = 1'b1;
            // rlast ends the burst regardless of how many beats arrived
            if (axi.rvalid && axi.rlast) state_nxt = FINISH;
         end
         FINISH: begin
            rd_AXI_finish = 1'b1;
            if (rd_reset) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         len_q  <= '0;
         count  <= '0;
         r_line <= '0;
      end else begin
         if (req_take) begin
            addr_q <= uncache ? rd_addr : {rd_addr[31:6], 6'b0};
            len_q  <= uncache ? 8'd0 : 8'd15;
            count  <= '0;
         end
         // count wraps after 16 beats; an over-long burst overwrites word 0
         if (beat_take) begin
            r_line[{count, 5'b0} +: 32] <= axi.rdata;
            count                       <= count + 4'd1;
         end
      end
   end

   assign axi.araddr  = addr_q;
   assign axi.arlen   = len_q;
   assign axi.arsize  = 3'b010;
   assign axi.arburst = 2'b01;

`ifdef CLAP_AXI_RRESP_CHECK_EN
   logic unused_rresp;
   assign unused_rresp = axi.rresp[0];

   always_ff @(posedge clk) begin
      if (rst)                           rd_err <= 1'b0;
      else if (req_take)                 rd_err <= 1'b0;
      else if (beat_take && axi.rresp[1]) rd_err <= 1'b1;
   end
`else
   logic unused_rresp;
   assign unused_rresp = ^axi.rresp;
   assign rd_err       = 1'b0;
`endif
endmodule

// File: doc/rd_buffer_axi.md
# rd_buffer_axi

Cache-refill read engine: the AXI4 read-channel counterpart of the cache write-back buffer. On a request from the cache FSM it issues one AR transaction, accepts the R beats, and assembles them into a 512-bit line register. It signals completion until the cache acknowledges. It sits between the cache controller and the AXI crossbar, next to the write buffer.

## Interface
- Parameters: none (line = 16 × 32-bit words, fixed).
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_req` in 1: start a read; sampled only in IDLE.
- `rd_addr` in 32: request address, latched with `rd_req`.
- `uncache` in 1: single-word access when 1; latched with `rd_req`.
- `rd_reset` in 1: cache acknowledges FINISH; return to IDLE.
- `arready` in 1: AR handshake from slave.
- `rvalid` in 1: R channel valid.
- `rdata` in 32: R channel data.
- `rresp` in 2: R channel response.
- `rlast` in 1: last beat of burst.
- `arvalid` out 1: AR valid.
- `araddr` out 32: AR address.
- `arlen` out 8: 15 when cached, 0 when uncached.
- `arsize` out 3: constant 3'b010.
- `arburst` out 2: constant 2'b01 (INCR).
- `rready` out 1: R ready.
- `r_line` out 512: assembled line; word k at bits [32k+31:32k].
- `rd_AXI_finish` out 1: transaction complete, data valid on `r_line`.
- `rd_err` out 1: error flag (see Configuration).

## Operation
- FSM states: IDLE, ADDR, RECV, FINISH.
- IDLE:
  - On `rd_req`, latch the address and `uncache`, then go to ADDR.
  - Cached: `araddr = {rd_addr[31:6], 6'b0}`. Uncached: `araddr = rd_addr`.
  - Clear the beat counter and `rd_err`.
- ADDR:
  - `arvalid=1`.
  - On `arvalid && arready`, go to RECV.
  - `araddr`, `arlen` and `arvalid` hold stable until the handshake.
- RECV:
  - `rready=1`.
  - Each `rvalid && rready` writes `rdata` into word `count` of `r_line` and increments the 4-bit `count`.
  - On a handshake with `rlast=1`, go to FINISH, whatever `count` is.
  - Short burst: unwritten words keep their old value.
  - Beats beyond 16 without `rlast`: `count` wraps to 0, and the 17th beat overwrites word 0. This is a protocol violation and is not guarded.
- FINISH:
  - `rd_AXI_finish=1`.
  - On `rd_reset`, go to IDLE.
  - `r_line` holds until the next request's first beat.
- Uncached: the single beat lands in `r_line[31:0]`.
- `rd_req` outside IDLE is ignored.
- `rd_reset` outside FINISH is ignored.
- `arvalid`, `rready` and `rd_AXI_finish` are decoded from state only.

## Timing
- Reset (`rst=1` at an edge), including mid-transaction:
  - Next cycle the state is IDLE.
  - `arvalid`, `rready`, `rd_AXI_finish`, `rd_err` are 0; `count`=0.
  - `r_line`, `araddr` are 0; `arlen`=0.
  - Any in-flight AXI transaction is abandoned; the interconnect is reset alongside.
- Latency:
  - `rd_req` sampled at edge E0 → `arvalid` high in the cycle after E0.
  - AR handshake at edge E1 → `rready` high from E1.
  - Beat data is visible on `r_line` in the cycle after its handshake edge.
  - `rlast` handshake at edge En → `rd_AXI_finish` high after En.
- Minimum cached refill: 1 (ADDR) + 16 beats, so `rd_AXI_finish` rises 18 cycles after `rd_req` is sampled, given zero-wait `arready`/`rvalid`.
- `rd_reset` held through FINISH → IDLE at the next edge. A new `rd_req` is accepted in the cycle after that.
- A simultaneous `rd_req` and `rd_reset` in FINISH: only `rd_reset` acts.

## Configuration
- `CLAP_AXI_RRESP_CHECK_EN` defined:
  - `rd_err` is set on any accepted beat with `rresp[1]=1` (SLVERR/DECERR).
  - `rd_err` is sticky until the next IDLE→ADDR transition or reset.
  - It is valid alongside `rd_AXI_finish`.
- Undefined: `rd_err` tied to 0 and `rresp` unused.

## Test plan
- Cached refill: `rd_addr`=0x1C00_0044, zero-wait slave, beats 0x0..0xF → `araddr`=0x1C00_0040, `arlen`=15, `r_line` word k = k, `rd_AXI_finish` 18 cycles after the request.
- Uncached read: `rd_addr`=0xBFAF_8004, `uncache`=1, single beat 0xDEAD_BEEF with `rlast` → `araddr` unchanged, `arlen`=0, `r_line[31:0]`=0xDEAD_BEEF, finish 3 cycles after the request.
- Backpressure: `arready` delayed 5 cycles, `rvalid` toggling every other cycle → `arvalid`/`araddr` stable throughout, all 16 words correct, no beat lost or duplicated.
- Handshake: finish held with `rd_reset`=0 for 10 cycles plus a second `rd_req` → stays in FINISH; after `rd_reset`, one cycle later a new `rd_req` is accepted.
- Mid-burst reset: `rst` after beat 7 → all outputs 0 next cycle; a fresh refill then completes correctly.
- With `CLAP_AXI_RRESP_CHECK_EN`: `rresp`=2'b10 on beat 3 → `rd_err`=1 at finish and cleared at the next request. Without the macro, `rd_err`=0 for the same stimulus.
